// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mul/div issue controller.
// Imported by the interface, the command queue and the top.
package muldiv_pkg;

    localparam int RES_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_DIV0 = 2'b01,
        ERR_TMO  = 2'b10
    } err_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    function automatic logic [RES_W-1:0] sext64(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// Request, core and response buses of the mul/div issue controller.
// slave = controller side, master = datapath/core/consumer side.
interface muldiv_issue_ctrl_if
    import muldiv_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_op1;
    logic [31:0]      req_op2;
    logic             req_muordi;
    logic [TAG_W-1:0] req_tag;

    logic             core_start;
    logic [31:0]      core_opera1;
    logic [RES_W-1:0] core_opera2;
    logic             core_muordi;
    logic             core_valid;
    logic [RES_W-1:0] core_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [RES_W-1:0] rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_err;
    logic             busy;

    modport slave (
        input  req_valid, req_op1, req_op2, req_muordi, req_tag,
        output req_ready,
        output core_start, core_opera1, core_opera2, core_muordi,
        input  core_valid, core_result,
        output rsp_valid, rsp_result, rsp_tag, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req_valid, req_op1, req_op2, req_muordi, req_tag,
        input  req_ready,
        input  core_start, core_opera1, core_opera2, core_muordi,
        output core_valid, core_result,
        input  rsp_valid, rsp_result, rsp_tag, rsp_err,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/muldiv_issue_ctrl_cmd_fifo.sv
// Command queue: small synchronous FIFO, power-of-2 depth.
// Extra pointer MSB tells full from empty.
module cmd_fifo
    import muldiv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 69
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    // Read/write pointers advance on accepted push/pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue front-end and result collector for the shift-add mul/div core.
// One operation in flight; responses return in request order.
module muldiv_issue_ctrl
    import muldiv_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 63
) (
    input logic               clock,
    input logic               reset,
    muldiv_issue_ctrl_if.slave bus
);
    localparam int ENT_W = 65 + TAG_W;
    localparam logic [7:0] TMO_LIM = TIMEOUT[7:0];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_op1;
    logic [31:0]      r_op2;
    logic             r_muordi;
    logic [TAG_W-1:0] r_tag;
    logic [RES_W-1:0] r_result;
    err_t             r_err;
    logic [7:0]       r_timer;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [ENT_W-1:0] w_in;
    logic [ENT_W-1:0] w_head;
    logic [31:0]      w_h_op1;
    logic [31:0]      w_h_op2;
    logic             w_h_muordi;
    logic [TAG_W-1:0] w_h_tag;
    logic             w_div0;
    logic             w_done_ok;
    logic             w_done_tmo;

    assign w_in = {bus.req_op1, bus.req_op2, bus.req_muordi, bus.req_tag};

    assign w_h_op1    = w_head[ENT_W-1 -: 32];
    assign w_h_op2    = w_head[TAG_W+1 +: 32];
    assign w_h_muordi = w_head[TAG_W];
    assign w_h_tag    = w_head[TAG_W-1:0];

    assign bus.req_ready = ~w_full & ~reset;
    assign w_push        = bus.req_valid & bus.req_ready;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, pop and completion decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_div0      = 1'b0;
        w_done_ok   = 1'b0;
        w_done_tmo  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_h_muordi == OP_DIV && w_h_op2 == '0) begin
                        w_div0      = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.core_valid) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_timer == TMO_LIM) begin
                    w_done_tmo  = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Issue register, result capture and WAIT timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_muordi <= 1'b0;
            r_tag    <= '0;
            r_result <= '0;
            r_err    <= ERR_OK;
            r_timer  <= '0;
        end else begin
            if (w_pop) begin
                r_op1    <= w_h_op1;
                r_op2    <= w_h_op2;
                r_muordi <= w_h_muordi;
                r_tag    <= w_h_tag;
            end
            unique case (1'b1)
                w_div0: begin
                    r_result <= '0;
                    r_err    <= ERR_DIV0;
                end
                w_done_tmo: begin
                    r_result <= '0;
                    r_err    <= ERR_TMO;
                end
                w_done_ok: begin
                    r_result <= bus.core_result;
                    r_err    <= ERR_OK;
                end
                default: ;
            endcase
            if (r_state == ST_ISSUE)
                r_timer <= '0;
            else if (r_state == ST_WAIT)
                r_timer <= r_timer + 8'd1;
        end
    end

    assign bus.core_start  = (r_state == ST_ISSUE);
    assign bus.core_opera1 = r_op1;
    assign bus.core_opera2 = sext64(r_op2);
    assign bus.core_muordi = r_muordi;

    assign bus.rsp_valid  = (r_state == ST_RESP);
    assign bus.rsp_result = r_result;
    assign bus.rsp_tag    = r_tag;
    assign bus.rsp_err    = r_err;
    assign bus.busy       = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Scoreboard bench for muldiv_issue_ctrl with a latency-programmable core model.
// Directed requests push expected starts/responses; monitors pop and compare.
`timescale 1ns/1ps
module tb_muldiv_issue_ctrl;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  tag;
        logic [1:0]  err;
    } rsp_exp_t;

    typedef struct packed {
        logic [31:0] op1;
        logic [63:0] op2;
        logic        mud;
    } st_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    muldiv_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    muldiv_issue_ctrl #(
        .DEPTH   (2),
        .TAG_W   (TAG_W),
        .TIMEOUT (63)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    rsp_exp_t rsp_q[$];
    st_exp_t  st_q[$];
    rsp_exp_t re;
    st_exp_t  se;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int core_lat  = -1;
    int n_start   = 0;
    int start_cyc = 0;
    int rsp_cyc   = 0;
    int n0        = 0;
    logic prev_start = 1'b0;
    logic [63:0] core_p;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic want_start(input logic [31:0] a, input logic [63:0] b2);
        st_q.push_back('{op1: a, op2: b2, mud: 1'b0});
    endtask

    task automatic want_rsp(input logic [63:0] r, input logic [3:0] t,
                            input logic [1:0] e);
        rsp_q.push_back('{res: r, tag: t, err: e});
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic m, input logic [3:0] t);
        bit ok;
        int n;
        bus.req_valid  = 1'b1;
        bus.req_op1    = a;
        bus.req_op2    = b;
        bus.req_muordi = m;
        bus.req_tag    = t;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 300) begin
            @(negedge clock);
            ok = bus.req_ready;
            @(posedge clock);
            #1;
            n++;
        end
        bus.req_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_accept tag=%0d actual=not_accepted required=accepted", t);
        end
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < lim) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (rsp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", rsp_q.size());
            rsp_q.delete();
        end
    endtask

    // Monitor: core issue pulses and response handshakes.
    always @(negedge clock) begin
        if (bus.core_start) begin
            chk("start_one_cycle", 64'(prev_start), 64'd0);
            if (st_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_start actual=start required=none");
            end else begin
                se = st_q.pop_front();
                chk("core_opera1", 64'(bus.core_opera1), 64'(se.op1));
                chk("core_opera2", bus.core_opera2, se.op2);
                chk("core_muordi", 64'(bus.core_muordi), 64'(se.mud));
            end
            n_start++;
            start_cyc = cyc;
        end
        prev_start = bus.core_start;
        if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_cyc = cyc;
            if (rsp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual_tag=%0d required=none",
                         bus.rsp_tag);
            end else begin
                re = rsp_q.pop_front();
                chk("rsp_result", bus.rsp_result, re.res);
                chk("rsp_tag", 64'(bus.rsp_tag), 64'(re.tag));
                chk("rsp_err", 64'(bus.rsp_err), 64'(re.err));
            end
        end
    end

    // Core model: product after core_lat cycles; negative latency = silent.
    initial begin
        bus.core_valid  = 1'b0;
        bus.core_result = '0;
        forever begin
            @(negedge clock);
            if (bus.core_start && core_lat >= 0) begin
                core_p = {{32{bus.core_opera1[31]}}, bus.core_opera1} *
                         bus.core_opera2;
                repeat (core_lat) @(posedge clock);
                #1;
                bus.core_valid  = 1'b1;
                bus.core_result = core_p;
                @(posedge clock);
                #1;
                bus.core_valid  = 1'b0;
                bus.core_result = '0;
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op1    = '0;
        bus.req_op2    = '0;
        bus.req_muordi = 1'b0;
        bus.req_tag    = '0;
        bus.rsp_ready  = 1'b0;
        reset          = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_core_start", 64'(bus.core_start), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rsp_result", bus.rsp_result, 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("idle_req_ready", 64'(bus.req_ready), 64'd1);
        bus.rsp_ready = 1'b1;

        // MUL 7 x -3
        core_lat = 34;
        want_start(32'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        want_rsp(64'hFFFF_FFFF_FFFF_FFEB, 4'd3, 2'b00);
        send(32'd7, 32'hFFFF_FFFD, 1'b0, 4'd3);
        drain(200);
        chk("mul_latency", 64'(rsp_cyc - start_cyc), 64'd35);

        // DIV 100 / 0
        n0 = n_start;
        want_rsp(64'd0, 4'd5, 2'b01);
        send(32'd100, 32'd0, 1'b1, 4'd5);
        chk("div0_not_yet", 64'(bus.rsp_valid), 64'd0);
        @(posedge clock);
        #1;
        chk("div0_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        drain(50);
        chk("div0_no_start", 64'(n_start - n0), 64'd0);

        // Timeout, then a normal request
        core_lat = -1;
        want_start(32'd5, 64'd6);
        want_rsp(64'd0, 4'd7, 2'b10);
        send(32'd5, 32'd6, 1'b0, 4'd7);
        drain(300);
        chk("tmo_latency", 64'(rsp_cyc - start_cyc), 64'd65);
        core_lat = 10;
        want_start(32'd3, 64'd4);
        want_rsp(64'd12, 4'd8, 2'b00);
        send(32'd3, 32'd4, 1'b0, 4'd8);
        drain(200);

        // Back-to-back with consumer stalled
        bus.rsp_ready = 1'b0;
        core_lat = 5;
        want_start(32'd1, 64'd1);
        want_rsp(64'd1, 4'd1, 2'b00);
        send(32'd1, 32'd1, 1'b0, 4'd1);
        want_start(32'd2, 64'd3);
        want_rsp(64'd6, 4'd2, 2'b00);
        send(32'd2, 32'd3, 1'b0, 4'd2);
        want_start(32'hFFFF_FFFC, 64'd5);
        want_rsp(64'hFFFF_FFFF_FFFF_FFEC, 4'd3, 2'b00);
        send(32'hFFFF_FFFC, 32'd5, 1'b0, 4'd3);
        want_start(32'd10, 64'd10);
        want_rsp(64'h64, 4'd4, 2'b00);
        bus.req_valid  = 1'b1;
        bus.req_op1    = 32'd10;
        bus.req_op2    = 32'd10;
        bus.req_muordi = 1'b0;
        bus.req_tag    = 4'd4;
        repeat (30) @(posedge clock);
        @(negedge clock);
        chk("full_req_ready", 64'(bus.req_ready), 64'd0);
        chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("hold_rsp_tag", 64'(bus.rsp_tag), 64'd1);
        @(posedge clock);
        #1;
        bus.rsp_ready = 1'b1;
        send(32'd10, 32'd10, 1'b0, 4'd4);
        drain(300);

        // Reset during WAIT
        core_lat = 30;
        want_start(32'd9, 64'd9);
        send(32'd9, 32'd9, 1'b0, 4'd9);
        repeat (12) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_rst_opera1", 64'(bus.core_opera1), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        chk("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        core_lat = 3;
        want_start(32'd2, 64'd2);
        want_rsp(64'h4, 4'd10, 2'b00);
        send(32'd2, 32'd2, 1'b0, 4'd10);
        drain(100);

        // core_valid on the timeout cycle
        core_lat = 64;
        want_start(32'd4, 64'd4);
        want_rsp(64'h10, 4'd11, 2'b00);
        send(32'd4, 32'd4, 1'b0, 4'd11);
        drain(300);

        repeat (5) @(posedge clock);
        #1;
        chk("starts_consumed", 64'(st_q.size()), 64'd0);
        chk("end_busy", 64'(bus.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
Request front-end and result collector for the signed shift-add multiplier/divider core. Accepts 32-bit operand pairs from the datapath over a valid/ready handshake and buffers them in a small command queue. Issues one operation at a time to the core: start pulse, 32-bit opera1, sign-extended 64-bit opera2, muordi select. Captures the 64-bit core result, or an error (divide-by-zero, timeout), and returns it to the consumer over a second valid/ready handshake.

Parameters:
DEPTH, 2, command queue entries (power of 2, >=2)
TAG_W, 4, request tag width, returned unchanged with the response
TIMEOUT, 63, maximum WAIT cycles before declaring core timeout (fits 8-bit timer)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  queue can accept
req_op1  in  32  operand 1 (signed)
req_op2  in  32  operand 2 (signed)
req_muordi  in  1  0 = multiply, 1 = divide
req_tag  in  TAG_W  request tag
core_start  out  1  one-cycle issue pulse to core
core_opera1  out  32  operand 1 to core
core_opera2  out  64  operand 2 sign-extended to 64 bits
core_muordi  out  1  operation select to core
core_valid  in  1  core result valid
core_result  in  64  core result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_result  out  64  result (0 on error)
rsp_tag  out  TAG_W  tag of the completed request
rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
busy  out  1  FSM not IDLE or queue non-empty

Behaviour:
- Reset (async, active-high): FSM to IDLE, queue emptied, timer 0. All outputs 0, including req_ready while reset is high. Reset mid-operation abandons the operation with no response; later core_valid is ignored.
- req_ready = queue not full. A push happens on an edge with req_valid & req_ready. No push while full, even if a pop occurs in the same cycle.
- Queue entry: {op1, op2, muordi, tag}, FIFO order. Responses are returned in request order.
- FSM states:
  - IDLE: if queue non-empty, pop the head into the issue register. If muordi=1 and op2==0, go to RESP with err=01 and result 0; the core is never started. Otherwise go to ISSUE.
  - ISSUE: core_start=1 for exactly this one cycle. Timer cleared. Go to WAIT.
  - WAIT: timer increments each cycle.
    - core_valid=1: capture core_result, err=00, go to RESP.
    - timer==TIMEOUT and no core_valid: result 0, err=10, go to RESP.
    - core_valid coincident with timeout: valid wins.
  - RESP: rsp_valid=1. rsp_result, rsp_tag and rsp_err are held stable until rsp_valid & rsp_ready, then go to IDLE.
- core_valid is ignored outside WAIT.
- core_opera1, core_opera2 and core_muordi are registered from the issue register. They are stable from ISSUE through the end of WAIT.
- core_opera2 = {{32{op2[31]}}, op2}.
- Latency: request accepted at edge 0 with the queue empty → IDLE pops at edge 1 → core_start high during cycle 1–2 → WAIT from edge 2. Divide-by-zero: rsp_valid high after edge 1. The queue may refill while the FSM is busy.
- Back-to-back: a new pop is possible on the edge after the RESP handshake.

Decomposition:
- Package muldiv_pkg:
  - FSM state encoding (IDLE, ISSUE, WAIT, RESP)
  - error codes ERR_OK=2'b00, ERR_DIV0=2'b01, ERR_TMO=2'b10
  - op select OP_MUL=0, OP_DIV=1
  - result width constant 64
- Sub-module cmd_fifo: synchronous FIFO with parameters DEPTH and width 65+TAG_W, async active-high reset, push/pop/full/empty.

Test Plan:
- MUL 7 × −3, tag 3; core model asserts core_valid 34 cycles after start with 64'hFFFF_FFFF_FFFF_FFEB → core_opera2=64'hFFFF_FFFF_FFFF_FFFD, one-cycle core_start, rsp_result=64'hFFFF_FFFF_FFFF_FFEB, rsp_err=00, rsp_tag=3.
- DIV 100 / 0, tag 5 → core_start never asserted, rsp_valid after edge 1, rsp_result=0, rsp_err=01, rsp_tag=5.
- Core model never asserts core_valid, TIMEOUT=63 → rsp_err=10, rsp_result=0 after 64 WAIT cycles. A following request completes normally.
- Four back-to-back requests (tags 1,2,3,4) with rsp_ready=0 → first three accepted, req_ready=0 on the fourth until the first response handshakes. Responses return with tags 1,2,3,4 in order.
- Reset asserted during WAIT; core_valid pulses after reset release → no response emitted, all outputs 0 during reset, busy=0. A fresh MUL 2×2 returns 64'h4.
- core_valid with result 64'h10 on the same cycle the timer hits TIMEOUT → rsp_err=00, rsp_result=64'h10.
